// File: rtl/rifl_crc_pkg.sv
// Shared definitions for the RIFL link CRC logic (transmit encoder and receive checker).
// Holds frame field widths, the CRC-8 polynomial, the lock-state enum and the
// 116-bit parallel CRC function. Both ends of the link must use the same crc8_116.
package rifl_crc_pkg;

  localparam int FRAME_W   = 128;
  localparam int PAYLOAD_W = 116;
  localparam int CRC_W     = 8;
  localparam int HDR_W     = 4;
  localparam int ERRCNT_W  = 16;

  // x^8 + x^7 + x^5 + x^2 + x + 1
  localparam logic [CRC_W-1:0] CRC_POLY = 8'hA7;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

  // MSB-first serial CRC unrolled over the whole payload; zero init, no final XOR.
  function automatic logic [CRC_W-1:0] crc8_116(input logic [PAYLOAD_W-1:0] payload);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = '0;
    for (int i = PAYLOAD_W - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ payload[i];
      c  = {c[CRC_W-2:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/rx_crc_check_if.sv
// Bundle between a frame source/sink and rx_crc_check.
// In: frame_in/valid_in (no backpressure), err_clr. Out: hdr_out, data_out, valid_out,
// crc_ok, crc_err, locked, err_cnt. master = environment side, slave = checker side.
interface rx_crc_check_if;
  import rifl_crc_pkg::*;

  logic [FRAME_W-1:0]   frame_in;
  logic                 valid_in;
  logic                 err_clr;
  logic [HDR_W-1:0]     hdr_out;
  logic [PAYLOAD_W-1:0] data_out;
  logic                 valid_out;
  logic                 crc_ok;
  logic                 crc_err;
  logic                 locked;
  logic [ERRCNT_W-1:0]  err_cnt;

  modport master (
    output frame_in, valid_in, err_clr,
    input  hdr_out, data_out, valid_out, crc_ok, crc_err, locked, err_cnt
  );

  modport slave (
    input  frame_in, valid_in, err_clr,
    output hdr_out, data_out, valid_out, crc_ok, crc_err, locked, err_cnt
  );

endinterface

// File: rtl/rx_seq_counter.sv
// Receive-side mirror of the transmitter sequence counter: 8-bit, wraps, load beats inc.
// Ports: clk, rst (sync, active-high), load/load_val (parallel load), inc (advance by 1),
// cnt (current value). Updates one cycle after load/inc; no backpressure.
module rx_seq_counter
  import rifl_crc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CRC_W-1:0] load_val,
  input  logic             inc,
  output logic [CRC_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= load_val;
    else if (inc)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/rx_crc_check.sv
// Receive frame checker: recomputes CRC-8 over the payload, verifies the sequence-folded
// checksum against a mirrored counter and tracks link lock (HUNT/VERIFY/LOCKED).
// Latency 2 cycles (valid_in at N -> outputs at N+2), one frame per cycle, no backpressure.
// Ports: clk, rst (sync, active-high), bus (rx_crc_check_if.slave).
// Optional: define RX_CRC_ERR_CNT_EN to build the saturating err_cnt and honour err_clr.
module rx_crc_check
  import rifl_crc_pkg::*;
#(
  parameter int LOCK_FRAMES = 4,  // consecutive VERIFY matches to lock (1..15)
  parameter int UNLOCK_ERRS = 3   // consecutive LOCKED mismatches to drop lock (1..15)
) (
  input  logic           clk,
  input  logic           rst,
  rx_crc_check_if.slave  bus
);

  // Stage 1: capture fields and the CRC of the payload.
  logic                 s1_vld;
  logic [HDR_W-1:0]     s1_hdr;
  logic [PAYLOAD_W-1:0] s1_pay;
  logic [CRC_W-1:0]     s1_crc;
  logic [CRC_W-1:0]     s1_f;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_hdr <= '0;
      s1_pay <= '0;
      s1_crc <= '0;
      s1_f   <= '0;
    end else begin
      s1_vld <= bus.valid_in;
      if (bus.valid_in) begin
        s1_hdr <= bus.frame_in[FRAME_W-1 -: HDR_W];
        s1_pay <= bus.frame_in[CRC_W +: PAYLOAD_W];
        s1_crc <= bus.frame_in[CRC_W-1:0];
        s1_f   <= crc8_116(bus.frame_in[CRC_W +: PAYLOAD_W]);
      end
    end
  end

  // Stage 2: compare and update lock state.
  lock_state_t      state_q, state_d;
  logic [3:0]       ok_run_q, ok_run_d;
  logic [3:0]       err_run_q, err_run_d;
  logic [CRC_W-1:0] rx_seq;
  logic [CRC_W-1:0] imp;
  logic             match;
  logic             seq_load, seq_inc;
  logic             ok_d, err_d;

  // The CRC field carries F(payload) ^ tx_seq, so XOR-ing F back out recovers tx_seq.
  assign imp   = s1_f ^ s1_crc;
  assign match = (imp == rx_seq);

  rx_seq_counter u_seq (
    .clk      (clk),
    .rst      (rst),
    .load     (seq_load),
    .load_val (imp + 1'b1),
    .inc      (seq_inc),
    .cnt      (rx_seq)
  );

  always_comb begin
    state_d   = state_q;
    ok_run_d  = ok_run_q;
    err_run_d = err_run_q;
    seq_load  = 1'b0;
    seq_inc   = 1'b0;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    if (s1_vld) begin
      unique case (state_q)
        HUNT: begin
          // Trust this frame's counter blindly; the following frames confirm it.
          seq_load = 1'b1;
          ok_run_d = '0;
          state_d  = VERIFY;
        end
        VERIFY: begin
          seq_inc = 1'b1;
          if (match) begin
            ok_d     = 1'b1;
            ok_run_d = ok_run_q + 4'd1;
            if (ok_run_d == 4'(LOCK_FRAMES)) begin
              state_d   = LOCKED;
              err_run_d = '0;
            end
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          seq_inc = 1'b1;
          if (match) begin
            ok_d      = 1'b1;
            err_run_d = '0;
          end else begin
            err_d     = 1'b1;
            err_run_d = err_run_q + 4'd1;
            if (err_run_d == 4'(UNLOCK_ERRS)) state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      ok_run_q      <= '0;
      err_run_q     <= '0;
      bus.valid_out <= 1'b0;
      bus.crc_ok    <= 1'b0;
      bus.crc_err   <= 1'b0;
      bus.hdr_out   <= '0;
      bus.data_out  <= '0;
    end else begin
      state_q       <= state_d;
      ok_run_q      <= ok_run_d;
      err_run_q     <= err_run_d;
      bus.valid_out <= s1_vld;
      bus.crc_ok    <= ok_d;
      bus.crc_err   <= err_d;
      if (s1_vld) begin
        bus.hdr_out  <= s1_hdr;
        bus.data_out <= s1_pay;
      end
    end
  end

  // state_q updates on the same edge as the frame outputs, so lock is reported in step.
  assign bus.locked = (state_q == LOCKED);

`ifdef RX_CRC_ERR_CNT_EN
  logic [ERRCNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                         err_cnt_q <= '0;
    else if (bus.err_clr && err_d)   err_cnt_q <= ERRCNT_W'(1);
    else if (bus.err_clr)            err_cnt_q <= '0;
    else if (err_d && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
  end

  assign bus.err_cnt = err_cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.err_cnt    = '0;
`endif

endmodule

// File: tb/tb_rx_crc_check.sv
// Bench for rx_crc_check: directed frames with hand-computed expectations pushed to a
// scoreboard queue; a negedge monitor pops and compares whenever valid_out is seen.
module tb_rx_crc_check;
  import rifl_crc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rx_crc_check_if bus ();

  rx_crc_check #(.LOCK_FRAMES(4), .UNLOCK_ERRS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int                   cyc;
    logic [HDR_W-1:0]     hdr;
    logic [PAYLOAD_W-1:0] data;
    logic                 ok;
    logic                 err;
    logic                 lk;
    logic [15:0]          cnt;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] hdr_ctr = 4'h3;
  logic       pend_clr = 1'b0;

  // Expected err_cnt only exists when the counter is built in.
  function automatic logic [15:0] ec(input int n);
`ifdef RX_CRC_ERR_CNT_EN
    return 16'(n);
`else
    return 16'd0 + 16'(n - n);
`endif
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [PAYLOAD_W-1:0] pay, input logic [7:0] crc,
                      input logic ok, input logic err, input logic lk,
                      input logic [15:0] cnt, input logic clr);
    exp_t e;
    bus.frame_in = {hdr_ctr, pay, crc};
    bus.valid_in = 1'b1;
    bus.err_clr  = pend_clr;
    pend_clr     = clr;
    e.cyc  = cyc + 2;
    e.hdr  = hdr_ctr;
    e.data = pay;
    e.ok   = ok;
    e.err  = err;
    e.lk   = lk;
    e.cnt  = cnt;
    sb.push_back(e);
    hdr_ctr = hdr_ctr + 4'd1;
    tick();
  endtask

  task automatic idle();
    bus.valid_in = 1'b0;
    bus.err_clr  = pend_clr;
    pend_clr     = 1'b0;
    tick();
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (bus.valid_out) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid_out", 128'(bus.valid_out), 128'(0));
      end else begin
        e = sb.pop_front();
        chk("latency_cycle", 128'(cyc),           128'(e.cyc));
        chk("hdr_out",       128'(bus.hdr_out),   128'(e.hdr));
        chk("data_out",      128'(bus.data_out),  128'(e.data));
        chk("crc_ok",        128'(bus.crc_ok),    128'(e.ok));
        chk("crc_err",       128'(bus.crc_err),   128'(e.err));
        chk("locked",        128'(bus.locked),    128'(e.lk));
        chk("err_cnt",       128'(bus.err_cnt),   128'(e.cnt));
      end
    end else begin
      chk("flags_without_valid", 128'({bus.crc_ok, bus.crc_err}), 128'(0));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout cycles=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] wrap_crc [4];
    logic [7:0] c;
    wrap_crc[0] = 8'hFE; wrap_crc[1] = 8'hFF; wrap_crc[2] = 8'h00; wrap_crc[3] = 8'h01;

    rst          = 1'b1;
    bus.valid_in = 1'b0;
    bus.frame_in = '0;
    bus.err_clr  = 1'b0;
    repeat (3) tick();
    chk("rst_valid_out", 128'(bus.valid_out), 128'(0));
    chk("rst_crc_ok",    128'(bus.crc_ok),    128'(0));
    chk("rst_crc_err",   128'(bus.crc_err),   128'(0));
    chk("rst_locked",    128'(bus.locked),    128'(0));
    chk("rst_err_cnt",   128'(bus.err_cnt),   128'(0));
    chk("rst_data_out",  128'(bus.data_out),  128'(0));
    rst = 1'b0;
    tick();

    // Acquire lock: zero payload so F=0 and CRC == tx sequence.
    send('0, 8'h10, 0, 0, 0, ec(0), 0);
    send('0, 8'h11, 1, 0, 0, ec(0), 0);
    send('0, 8'h12, 1, 0, 0, ec(0), 0);
    send('0, 8'h13, 1, 0, 0, ec(0), 0);
    send('0, 8'h14, 1, 0, 1, ec(0), 0);
    send('0, 8'h15, 1, 0, 1, ec(0), 0);

    // Run the counter up to the wrap point.
    for (int s = 'h16; s <= 'hFD; s++) send('0, 8'(s), 1, 0, 1, ec(0), 0);
    for (int i = 0; i < 4; i++) send('0, wrap_crc[i], 1, 0, 1, ec(0), 0);

    // Non-zero payloads: F(1)=0xA7, F(2)=0xE9.
    send(116'h1, 8'hA5, 1, 0, 1, ec(0), 0);   // 0xA7 ^ 0x02
    send(116'h2, 8'hEA, 1, 0, 1, ec(0), 0);   // 0xE9 ^ 0x03

    // Isolated errors (CRC bit 3 flipped), then clear coinciding with an error.
    send('0, 8'h0C, 0, 1, 1, ec(1), 0);
    send('0, 8'h05, 1, 0, 1, ec(1), 0);
    send('0, 8'h0E, 0, 1, 1, ec(2), 0);
    send('0, 8'h07, 1, 0, 1, ec(2), 0);
    send('0, 8'h00, 0, 1, 1, ec(1), 1);
    send('0, 8'h09, 1, 0, 1, ec(1), 0);
    repeat (4) idle();
    chk("err_cnt_before_clr", 128'(bus.err_cnt), 128'(ec(1)));
    pend_clr = 1'b1;
    idle();
    idle();
    chk("err_cnt_after_clr", 128'(bus.err_cnt), 128'(0));

    // Gaps of 1..5 idle cycles must not move rx_seq.
    for (int g = 1; g <= 5; g++) begin
      c = 8'h0A + 8'(g - 1);
      send('0, c, 1, 0, 1, ec(0), 0);
      repeat (g) idle();
    end

    // Three consecutive errors drop lock; HUNT, a VERIFY failure, then re-lock.
    send('0, 8'h07, 0, 1, 1, ec(1), 0);
    send('0, 8'h18, 0, 1, 1, ec(2), 0);
    send('0, 8'h19, 0, 1, 0, ec(3), 0);
    send('0, 8'h12, 0, 0, 0, ec(3), 0);
    send('0, 8'h13, 1, 0, 0, ec(3), 0);
    send('0, 8'h1C, 0, 0, 0, ec(3), 0);
    send('0, 8'h15, 0, 0, 0, ec(3), 0);
    send('0, 8'h16, 1, 0, 0, ec(3), 0);
    send('0, 8'h17, 1, 0, 0, ec(3), 0);
    send('0, 8'h18, 1, 0, 0, ec(3), 0);
    send('0, 8'h19, 1, 0, 1, ec(3), 0);
    repeat (4) idle();
    chk("locked_before_rst", 128'(bus.locked), 128'(1));

    // Reset one cycle after a frame: that frame must vanish.
    bus.frame_in = {4'h0, 116'h0, 8'h1A};
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_mid_valid_out", 128'(bus.valid_out), 128'(0));
    tick();
    rst = 1'b0;
    repeat (4) idle();
    chk("rst_mid_locked",  128'(bus.locked),  128'(0));
    chk("rst_mid_err_cnt", 128'(bus.err_cnt), 128'(0));

    // Fresh acquisition after reset.
    send('0, 8'h33, 0, 0, 0, ec(0), 0);
    send('0, 8'h34, 1, 0, 0, ec(0), 0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) idle();
    chk("scoreboard_drained", 128'(sb.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
